// File: rtl/lcd_arb_pkg.sv
// Shared types and default timing for the two-requester LCD write-bus arbiter.
package lcd_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SETUP     = 3'd1,
    ST_STROBE_LO = 3'd2,
    ST_STROBE_HI = 3'd3,
    ST_GAP       = 3'd4,
    ST_RELEASE   = 3'd5
  } lcd_state_e;

  localparam int WR_LOW_CYC_DEF  = 2;
  localparam int WR_HIGH_CYC_DEF = 2;
  localparam int TIMEOUT_CYC_DEF = 255;
  localparam int PHASE_W         = 4;
  localparam int TMO_W           = 8;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/lcd_wr_timer.sv
// Reloadable down-counter; done is high once the loaded count has run out.
module lcd_wr_timer
  import lcd_arb_pkg::*;
#(
  parameter int WIDTH = TMO_W
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             done
);

  logic [WIDTH-1:0] cnt_r;

  // Reload on request, otherwise count down and stick at zero.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_r <= {WIDTH{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (cnt_r != {WIDTH{1'b0}}) begin
      cnt_r <= cnt_r - WIDTH'(1);
    end
  end

  assign done = (cnt_r == {WIDTH{1'b0}});

endmodule

// File: rtl/lcd_bus_arbiter.sv
// Round-robin arbiter between two byte streams sharing one 8080-style LCD write bus.
module lcd_bus_arbiter
  import lcd_arb_pkg::*;
#(
  parameter int WR_LOW_CYC  = WR_LOW_CYC_DEF,
  parameter int WR_HIGH_CYC = WR_HIGH_CYC_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic [1:0]      req_valid,
  input  logic [1:0][7:0] req_data,
  input  logic [1:0]      req_dcx,
  input  logic [1:0]      req_last,
  output logic [1:0]      req_ready,
  output logic [1:0]      grant,
  output logic [7:0]      lcd_d,
  output logic            lcd_dcx,
  output logic            lcd_wrx_n,
  output logic            lcd_csx_n,
  output logic            busy,
  output logic            timeout_err
);

  lcd_state_e state_r;
  lcd_state_e next_state_s;
  logic       owner_r;
  logic       last_grant_r;
  logic       last_r;
  logic [1:0] grant_r;
  logic [7:0] lcd_d_r;
  logic       lcd_dcx_r;
  logic       wrx_n_r;
  logic       csx_n_r;
  logic       busy_r;
  logic       tmo_err_r;
  logic       accept_s;
  logic       sel_s;
  logic       load_s;
  logic [TMO_W-1:0] load_val_s;
  logic       tmr_done_s;

  // Next-state decode and the single-cycle accept decision.
  always_comb begin
    next_state_s = state_r;
    accept_s     = 1'b0;
    sel_s        = owner_r;
    case (state_r)
      ST_IDLE: begin
        if (req_valid != 2'b00) begin
          accept_s     = 1'b1;
          sel_s        = (req_valid == 2'b11) ? ~last_grant_r : req_valid[1];
          next_state_s = ST_SETUP;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_SETUP: next_state_s = ST_STROBE_LO;
      ST_STROBE_LO: begin
        if (tmr_done_s) begin
          next_state_s = ST_STROBE_HI;
        end else begin
          next_state_s = ST_STROBE_LO;
        end
      end
      ST_STROBE_HI: begin
        if (!tmr_done_s) begin
          next_state_s = ST_STROBE_HI;
        end else if (last_r) begin
          next_state_s = ST_RELEASE;
        end else if (req_valid[owner_r]) begin
          accept_s     = 1'b1;
          next_state_s = ST_SETUP;
        end else begin
          next_state_s = ST_GAP;
        end
      end
      ST_GAP: begin
        if (req_valid[owner_r]) begin
          accept_s     = 1'b1;
          next_state_s = ST_SETUP;
        end else if (tmr_done_s) begin
          next_state_s = ST_RELEASE;
        end else begin
          next_state_s = ST_GAP;
        end
      end
      ST_RELEASE: next_state_s = ST_IDLE;
      default:    next_state_s = ST_IDLE;
    endcase
  end

  // Every state entry reloads the timer with that state's length minus one.
  always_comb begin
    load_s = (next_state_s != state_r);
    case (next_state_s)
      ST_STROBE_LO: load_val_s = {4'h0, PHASE_W'(WR_LOW_CYC - 1)};
      ST_STROBE_HI: load_val_s = {4'h0, PHASE_W'(WR_HIGH_CYC - 1)};
      ST_GAP:       load_val_s = TMO_W'(TIMEOUT_CYC - 1);
      default:      load_val_s = 8'h00;
    endcase
  end

  lcd_wr_timer #(
    .WIDTH(TMO_W)
  ) u_timer (
    .clk     (clk),
    .nrst    (nrst),
    .load    (load_s),
    .load_val(load_val_s),
    .done    (tmr_done_s)
  );

  // FSM state plus all registered panel and status outputs.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r      <= ST_IDLE;
      owner_r      <= 1'b0;
      last_grant_r <= 1'b1;
      last_r       <= 1'b0;
      grant_r      <= 2'b00;
      lcd_d_r      <= 8'h00;
      lcd_dcx_r    <= 1'b0;
      wrx_n_r      <= 1'b1;
      csx_n_r      <= 1'b1;
      busy_r       <= 1'b0;
      tmo_err_r    <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      busy_r    <= (next_state_s != ST_IDLE);
      wrx_n_r   <= (next_state_s != ST_STROBE_LO);
      csx_n_r   <= (next_state_s == ST_IDLE) || (next_state_s == ST_RELEASE);
      tmo_err_r <= (state_r == ST_GAP) && (next_state_s == ST_RELEASE);
      if (accept_s) begin
        owner_r   <= sel_s;
        grant_r   <= onehot2(sel_s);
        lcd_d_r   <= req_data[sel_s];
        lcd_dcx_r <= req_dcx[sel_s];
        last_r    <= req_last[sel_s];
      end
      if (next_state_s == ST_RELEASE) begin
        grant_r      <= 2'b00;
        last_grant_r <= owner_r;
      end
    end
  end

  assign req_ready   = accept_s ? onehot2(sel_s) : 2'b00;
  assign grant       = grant_r;
  assign lcd_d       = lcd_d_r;
  assign lcd_dcx     = lcd_dcx_r;
  assign lcd_wrx_n   = wrx_n_r;
  assign lcd_csx_n   = csx_n_r;
  assign busy        = busy_r;
  assign timeout_err = tmo_err_r;

endmodule
